// File: rtl/ctrl_fsm_param.sv
// Parametrised fetch/decode/execute control unit with instruction-memory and multi-cycle ALU handshakes.
// Optional feature macro: CTRL_SINGLE_STEP_EN (adds input step; S_NEXT waits for step=1).
module ctrl_fsm_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned PC_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic                  imem_valid,
    input  logic [2*REG_AW+1:0]   imem_instr,
    output logic [REG_AW-1:0]     rf_raddr_a,
    output logic [REG_AW-1:0]     rf_raddr_b,
    input  logic [DATA_W-1:0]     rf_rdata_a,
    input  logic [DATA_W-1:0]     rf_rdata_b,
    output logic                  rf_we,
    output logic [REG_AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [1:0]            alu_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic                  alu_start,
    input  logic                  alu_done,
    input  logic [DATA_W-1:0]     alu_result,
    output logic [2:0]            cpu_stage,
    output logic [3:0]            state,
    output logic                  flag_zero,
    output logic                  halted
);

    localparam int unsigned INSTR_W = 2 + 2*REG_AW;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_ALU    = 4'd2,
        S_WAIT   = 4'd3,
        S_WB     = 4'd4,
        S_WB2    = 4'd5,
        S_NEXT   = 4'd6,
        S_HALT   = 4'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;
    logic [DATA_W-1:0]   r_result;
    logic                r_flag_zero;

    logic [1:0]          w_op;
    logic [REG_AW-1:0]   w_ra;
    logic [REG_AW-1:0]   w_rb;
    logic                w_is_add;
    logic                w_is_sub;
    logic                w_is_swap;
    logic                w_is_mov;
    logic                w_is_nop;
    logic                w_is_halt;
    logic                w_step_ok;

`ifdef CTRL_SINGLE_STEP_EN
    assign w_step_ok = step;
`else
    assign w_step_ok = 1'b1;
`endif

    assign w_op      = r_ir[INSTR_W-1 -: 2];
    assign w_ra      = r_ir[2*REG_AW-1 -: REG_AW];
    assign w_rb      = r_ir[REG_AW-1:0];
    assign w_is_add  = (w_op == 2'b01);
    assign w_is_sub  = (w_op == 2'b10);
    assign w_is_swap = (w_op == 2'b11);
    // op 00 splits three ways on the register fields: MOV, NOP, or HALT (ra==rb==all-ones)
    assign w_is_mov  = (w_op == 2'b00) && (w_ra != w_rb);
    assign w_is_halt = (w_op == 2'b00) && (w_ra == w_rb) && (&w_ra);
    assign w_is_nop  = (w_op == 2'b00) && (w_ra == w_rb) && !(&w_ra);

    assign imem_addr  = r_pc;
    assign rf_raddr_a = w_ra;
    assign rf_raddr_b = w_rb;
    assign alu_op     = w_is_add ? 2'b01 : (w_is_sub ? 2'b10 : 2'b00);
    assign alu_a      = r_opa;
    assign alu_b      = r_opb;
    assign flag_zero  = r_flag_zero;
    assign state      = r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_FETCH;
            r_pc        <= '0;
            r_ir        <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_result    <= '0;
            r_flag_zero <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH:  if (imem_valid) r_ir <= imem_instr;
                S_DECODE: begin
                    r_opa <= rf_rdata_a;
                    r_opb <= rf_rdata_b;
                end
                S_WAIT:   if (alu_done) r_result <= alu_result;
                S_WB:     if (w_is_add || w_is_sub) r_flag_zero <= (r_result == '0);
                S_NEXT:   if (w_step_ok) r_pc <= r_pc + PC_W'(1);
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        imem_req  = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        alu_start = 1'b0;
        cpu_stage = 3'b100;
        halted    = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req  = 1'b1;
                cpu_stage = 3'b001;
                if (imem_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                cpu_stage = 3'b010;
                if (w_is_add || w_is_sub)       w_next = S_ALU;
                else if (w_is_mov || w_is_swap) w_next = S_WB;
                else if (w_is_halt)             w_next = S_HALT;
                else if (w_is_nop)              w_next = S_NEXT;
                else                            w_next = S_NEXT;
            end
            S_ALU: begin
                alu_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done) w_next = S_WB;
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = w_ra;
                rf_wdata = (w_is_add || w_is_sub) ? r_result : r_opb;
                w_next   = w_is_swap ? S_WB2 : S_NEXT;
            end
            S_WB2: begin
                rf_we    = 1'b1;
                rf_waddr = w_rb;
                rf_wdata = r_opa;
                w_next   = S_NEXT;
            end
            S_NEXT: begin
                if (w_step_ok) w_next = S_FETCH;
            end
            S_HALT: begin
                cpu_stage = 3'b000;
                halted    = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Self-checking bench for ctrl_fsm_param: directed vector table, random instructions against an
// architectural model (register values, pc, zero flag, cycle counts), and reset/halt/wrap sequences.
module tb_ctrl_fsm_param;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_valid;
    logic [7:0]    imem_instr;
    logic [AW-1:0] rf_raddr_a, rf_raddr_b;
    logic [DW-1:0] rf_rdata_a, rf_rdata_b;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [1:0]    alu_op;
    logic [DW-1:0] alu_a, alu_b;
    logic          alu_start;
    logic          alu_done;
    logic [DW-1:0] alu_result;
    logic [2:0]    cpu_stage;
    logic [3:0]    dbg_state;
    logic          flag_zero;
    logic          halted;
`ifdef CTRL_SINGLE_STEP_EN
    logic          step = 1'b1;
`endif

    ctrl_fsm_param #(.DATA_W(DW), .REG_AW(AW), .PC_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CTRL_SINGLE_STEP_EN
        .step       (step),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_instr (imem_instr),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .cpu_stage  (cpu_stage),
        .state      (dbg_state),
        .flag_zero  (flag_zero),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Register file environment (with a preset port used only while reset is held)
    logic [DW-1:0] rf_mem [8];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    assign rf_rdata_a = rf_mem[rf_raddr_a];
    assign rf_rdata_b = rf_mem[rf_raddr_b];
    always @(posedge clk) begin
        if (pre_en)     rf_mem[pre_addr] <= pre_data;
        else if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Architectural reference state
    int ref_rf [8];
    int ref_pc;
    int ref_flag;
    int ewr_a[$], ewr_d[$];
    int wr_a[$],  wr_d[$];
    int seen_op;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Instruction semantics at the ISA level: expected cycles, ALU starts, writes and new state.
    task automatic model(input logic [7:0] instr, input int n, output int e_cyc, output int e_start,
                         output int e_op);
        int op, ra, rb, res, ta, tb;
        op = instr / 64; ra = (instr / 8) % 8; rb = instr % 8;
        ewr_a.delete(); ewr_d.delete();
        e_start = 0; e_op = 0;
        if (op == 1 || op == 2) begin
            res = (op == 1) ? (ref_rf[ra] + ref_rf[rb]) % 256 : (ref_rf[ra] - ref_rf[rb] + 256) % 256;
            ewr_a.push_back(ra); ewr_d.push_back(res);
            ref_rf[ra] = res;
            ref_flag = (res == 0) ? 1 : 0;
            e_cyc = 6 + n; e_start = 1; e_op = op;
        end else if (op == 3) begin
            ta = ref_rf[ra]; tb = ref_rf[rb];
            ewr_a.push_back(ra); ewr_d.push_back(tb);
            ewr_a.push_back(rb); ewr_d.push_back(ta);
            ref_rf[ra] = tb; ref_rf[rb] = ta;
            e_cyc = 5;
        end else if (ra != rb) begin
            ewr_a.push_back(ra); ewr_d.push_back(ref_rf[rb]);
            ref_rf[ra] = ref_rf[rb];
            e_cyc = 4;
        end else begin
            e_cyc = 3;
        end
        ref_pc = (ref_pc + 1) % (1 << PW);
    endtask

    // Drives one instruction from a fetch cycle; acts as imem and ALU; returns at next fetch or halt.
    task automatic run_instr(input logic [7:0] instr, input int vd, input int n, input bit early,
                             output int cyc, output int nstart);
        int alu_cnt, guard;
        logic [1:0]    s_op;
        logic [DW-1:0] s_a, s_b;
        alu_cnt = -1; guard = 0; nstart = 0;
        s_op = '0; s_a = '0; s_b = '0;
        wr_a.delete(); wr_d.delete();
        for (int i = 0; i < vd; i++) begin
            imem_valid = 1'b0;
            imem_instr = 8'($urandom);
            chk("req_held", imem_req, 1);
            @(posedge clk); #1;
        end
        chk("req_valid_cycle", {imem_req, cpu_stage}, {1'b1, 3'b001});
        imem_valid = 1'b1;
        imem_instr = instr;
        cyc = 1;
        forever begin
            @(posedge clk); #1;
            imem_valid = 1'($urandom_range(0, 1));
            imem_instr = 8'($urandom);
            alu_done   = 1'b0;
            if (cpu_stage == 3'b001 || halted) break;
            cyc++;
            if (rf_we) begin
                wr_a.push_back(int'(rf_waddr));
                wr_d.push_back(int'(rf_wdata));
            end
            if (alu_start) begin
                nstart++;
                alu_cnt = n;
                s_op = alu_op; s_a = alu_a; s_b = alu_b;
                seen_op = int'(alu_op);
                if (early) begin
                    alu_done   = 1'b1;
                    alu_result = 8'($urandom);
                end
            end else if (alu_cnt == 0) begin
                chk("alu_stable", {alu_op, alu_a, alu_b}, {s_op, s_a, s_b});
                alu_done   = 1'b1;
                alu_result = (alu_op == 2'b01) ? alu_a + alu_b : alu_a - alu_b;
                alu_cnt    = -1;
            end else if (alu_cnt > 0) begin
                alu_cnt--;
            end
            guard++;
            if (guard > 200) begin
                chk("instr_timeout", 1, 0);
                break;
            end
        end
        if (!halted) imem_valid = 1'b0;
    endtask

    task automatic check_instr(input string tag, input logic [7:0] instr, input int vd, input int n,
                               input bit early, output int cyc);
        int e_cyc, e_start, e_op, nstart;
        model(instr, n, e_cyc, e_start, e_op);
        seen_op = 0;
        run_instr(instr, vd, n, early, cyc, nstart);
        chk({tag, "_cycles"}, cyc, e_cyc);
        chk({tag, "_alu_starts"}, nstart, e_start);
        if (e_start != 0) chk({tag, "_alu_op"}, seen_op, e_op);
        chk({tag, "_pc"}, imem_addr, ref_pc);
        chk({tag, "_flag"}, flag_zero, ref_flag);
        chk({tag, "_nwrites"}, wr_a.size(), ewr_a.size());
        for (int i = 0; i < wr_a.size() && i < ewr_a.size(); i++) begin
            chk({tag, "_waddr"}, wr_a[i], ewr_a[i]);
            chk({tag, "_wdata"}, wr_d[i], ewr_d[i]);
        end
        for (int r = 0; r < 8; r++) chk({tag, "_reg"}, rf_mem[r], ref_rf[r]);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ref_pc = 0; ref_flag = 0;
    endtask

    typedef struct {
        logic [7:0] instr;
        int         vd;
        int         n;
        bit         early;
        int         exp_cyc;
        int         exp_flag;
        int         exp_pc;
    } vec_t;

    initial begin
        vec_t tbl [8];
        int   pre [8];
        int   cyc, hold_pc;
        logic [7:0] ri;

        tbl[0] = '{8'h4A, 0, 1, 1'b0, 7, 0, 1};   // ADD r1,r2: 5+3=8
        tbl[1] = '{8'h9B, 0, 0, 1'b0, 6, 1, 2};   // SUB r3,r3 -> 0, zero flag
        tbl[2] = '{8'h29, 0, 0, 1'b0, 4, 1, 3};   // MOV r5,r1 keeps flag
        tbl[3] = '{8'h12, 3, 0, 1'b0, 3, 1, 4};   // NOP, valid delayed 3 cycles
        tbl[4] = '{8'hF7, 0, 0, 1'b0, 5, 1, 5};   // SWAP r6,r7 (AA,55)
        tbl[5] = '{8'hD2, 0, 0, 1'b0, 5, 1, 6};   // SWAP r2,r2
        tbl[6] = '{8'h49, 0, 2, 1'b1, 8, 0, 7};   // ADD r1,r1 with done coincident with start
        tbl[7] = '{8'h84, 1, 3, 1'b0, 9, 0, 8};   // SUB r0,r4: 0-0x11=0xEF
        pre = '{0, 5, 3, 7, 8'h11, 8'h22, 8'hAA, 8'h55};

        rst = 1'b0; imem_valid = 1'b0; imem_instr = '0; alu_done = 1'b0; alu_result = '0;
        for (int r = 0; r < 8; r++) begin
            pre_en = 1'b1; pre_addr = 3'(r); pre_data = 8'(pre[r]);
            ref_rf[r] = pre[r];
            @(posedge clk); #1;
        end
        pre_en = 1'b0;
        ref_pc = 0; ref_flag = 0;
        chk("rst_stage", cpu_stage, 3'b001);
        chk("rst_pc", imem_addr, 0);
        chk("rst_ctrl", {rf_we, alu_start, halted, flag_zero}, 4'b0000);
        chk("rst_latches", {alu_op, alu_a, alu_b, rf_raddr_a, rf_raddr_b}, '0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            check_instr("vec", tbl[i].instr, tbl[i].vd, tbl[i].n, tbl[i].early, cyc);
            chk("vec_tbl_cycles", cyc, tbl[i].exp_cyc);
            chk("vec_tbl_flag", flag_zero, tbl[i].exp_flag);
            chk("vec_tbl_pc", imem_addr, tbl[i].exp_pc);
        end

        for (int i = 0; i < 40; i++) begin
            ri = 8'($urandom);
            if (ri == 8'h3F) ri = 8'h00;
            check_instr("rnd", ri, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), cyc);
        end

        // pc wrap: 16 NOPs from pc 0 return to 0
        pulse_reset();
        chk("wrap_start_pc", imem_addr, 0);
        for (int i = 0; i < 16; i++) check_instr("wrap", 8'h09 * 8'($urandom_range(0, 6)), 0, 0, 1'b0, cyc);
        chk("wrap_end_pc", imem_addr, 0);

        // reset while the ALU is outstanding aborts the write
        check_instr("pre_wait", 8'h00, 0, 0, 1'b0, cyc);
        imem_valid = 1'b1; imem_instr = 8'h4A;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            imem_valid = 1'b0; alu_done = 1'b0;
        end
        chk("wait_state_reached", {alu_start, rf_we, cpu_stage}, {1'b0, 1'b0, 3'b100});
        pulse_reset();
        chk("wait_rst_stage", cpu_stage, 3'b001);
        chk("wait_rst_pc", imem_addr, 0);
        chk("wait_rst_ir", {rf_raddr_a, rf_raddr_b, alu_op, alu_a, alu_b}, '0);
        begin
            int saw_we = 0;
            for (int i = 0; i < 10; i++) begin
                alu_done = 1'b1; alu_result = 8'h3C;
                @(posedge clk); #1;
                if (rf_we) saw_we++;
            end
            alu_done = 1'b0;
            chk("wait_rst_no_write", saw_we, 0);
        end
        for (int r = 0; r < 8; r++) chk("wait_rst_reg", rf_mem[r], ref_rf[r]);

        // HALT freezes until reset
        check_instr("pre_halt", 8'h5B, 0, 0, 1'b0, cyc);
        hold_pc = ref_pc;
        begin
            int nst;
            run_instr(8'h3F, 0, 0, 1'b0, cyc, nst);
        end
        chk("halt_latency", cyc, 2);
        for (int i = 0; i < 20; i++) begin
            chk("halt_hold", {halted, cpu_stage, imem_req, imem_addr}, {1'b1, 3'b000, 1'b0, 4'(hold_pc)});
            imem_valid = 1'($urandom_range(0, 1)); imem_instr = 8'($urandom);
            @(posedge clk); #1;
        end
        imem_valid = 1'b0;
        pulse_reset();
        chk("halt_rst", {halted, cpu_stage, imem_addr}, {1'b0, 3'b001, 4'd0});
        check_instr("post_halt", 8'h24, 0, 0, 1'b0, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
